// File: rtl/moss_uart_pkg.sv
// Shared types for the UART transmit path: byte width, byte type, TX FIFO read FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package moss_uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } tx_fifo_state_t;

endpackage

// File: rtl/fifo_mem.sv
// Byte storage for the TX FIFO: DEPTH x DATA_W array, synchronous write, asynchronous head read.
// Latency: write visible on rd_data the cycle after the write edge; read is combinational.
// Backpressure: none here; the owner guarantees wr_en only when a slot is free.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr -> rd_data read port.
module fifo_mem
   import moss_uart_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int DATA_W = UART_DATA_W,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   // Storage is deliberately not reset: the pointers define which entries are valid.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: buffers producer bytes and issues them one at a time via send/busy.
// Latency: byte written in cycle N is popped in N+1 and pulsed out with tx_send in N+2.
// Backpressure: wr_ready drops when DEPTH bytes are held; a rejected writer must hold its data.
// Ports: clk, reset_n (async active-low); wr_valid/wr_ready/wr_data producer side;
//        tx_data/tx_send/tx_busy uart_tx side; level/empty occupancy status.
//        UART_TX_FIFO_STATS_EN adds sent_count (saturating tx_send count) and hi_water (peak level).
module uart_tx_fifo
   import moss_uart_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int DATA_W = UART_DATA_W,
   localparam int AW     = $clog2(DEPTH),
   localparam int LW     = AW + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_send,
   input  logic              tx_busy,
   output logic [LW-1:0]     level,
   output logic              empty
`ifdef UART_TX_FIFO_STATS_EN
   ,
   output logic [15:0]       sent_count,
   output logic [LW-1:0]     hi_water
`endif
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              full;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] head;
   tx_fifo_state_t    state;
   tx_fifo_state_t    state_nxt;

   // Extra wrap bit on each pointer separates full from empty; the difference
   // wraps modulo 2*DEPTH and therefore never exceeds DEPTH.
   assign level    = wr_ptr - rd_ptr;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_ready = !full;
   assign push     = wr_valid && !full;

   fifo_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (wr_data),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (head)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tx_data <= '0;
         state   <= IDLE;
      end else begin
         state <= state_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         // tx_data only moves on a pop, which needs busy low, so it is
         // stable for the whole frame uart_tx is shifting out.
         if (pop) begin
            rd_ptr  <= rd_ptr + PTR_ONE;
            tx_data <= head;
         end
      end
   end

   // Pop is taken on the IDLE->SEND edge so the byte is already in tx_data
   // during the single SEND cycle that pulses tx_send.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      tx_send   = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && !tx_busy) begin
               pop       = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            tx_send   = 1'b1;
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef UART_TX_FIFO_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sent_count <= '0;
         hi_water   <= '0;
      end else begin
         if (tx_send && (sent_count != 16'hFFFF)) begin
            sent_count <= sent_count + 16'd1;
         end
         if (level > hi_water) begin
            hi_water <= level;
         end
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          reset_n;
   logic          wr_valid;
   logic          wr_ready;
   logic [7:0]    wr_data;
   logic [7:0]    tx_data;
   logic          tx_send;
   logic          tx_busy;
   logic [LW-1:0] level;
   logic          empty;
`ifdef UART_TX_FIFO_STATS_EN
   logic [15:0]   sent_count;
   logic [LW-1:0] hi_water;
`endif

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .tx_data    (tx_data),
      .tx_send    (tx_send),
      .tx_busy    (tx_busy),
      .level      (level),
      .empty      (empty)
`ifdef UART_TX_FIFO_STATS_EN
      ,
      .sent_count (sent_count),
      .hi_water   (hi_water)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: bytes accepted but not yet handed to uart_tx, plus counters.
   logic [7:0] model_q [$];
   int         pushes;
   int         sends;
   int         hi_model;
   logic [7:0] last_sent;
   int         send_edge;
   int         edges;
   // uart_tx busy model
   int         busy_cnt;
   bit         send_prev;
   bit         force_busy;
   int         frame_lo;
   int         frame_hi;
   // scoring
   int         passes;
   int         fails;
   int         total;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: present inputs, take the edge, then at the falling edge score
   // outputs against the model and advance the uart_tx busy model.
   task automatic step(input bit v, input logic [7:0] d);
      bit         will_push;
      bit         busy_seen;
      int         lvl;
      logic [7:0] exp_b;
      wr_valid  = v;
      wr_data   = d;
      will_push = v && wr_ready;
      @(posedge clk);
      edges++;
      if (will_push) begin
         model_q.push_back(d);
         pushes++;
      end
      @(negedge clk);
      busy_seen = tx_busy;
      if (tx_send) begin
         chk("send_while_busy", 32'(busy_seen), 32'd0);
         if (model_q.size() == 0) begin
            chk("spurious_send", 32'd1, 32'd0);
         end else begin
            exp_b = model_q.pop_front();
            chk("tx_data_order", 32'(tx_data), 32'(exp_b));
         end
         last_sent = tx_data;
         sends++;
         send_edge = edges;
      end else if (busy_seen && sends > 0) begin
         chk("tx_data_hold", 32'(tx_data), 32'(last_sent));
      end
      // Occupancy = accepted bytes minus bytes already pulsed out (the pop
      // edge is the same edge that makes tx_send visible).
      lvl = pushes - sends;
      if (lvl > hi_model) hi_model = lvl;
      chk("level", 32'(level), 32'(lvl));
      chk("wr_ready", 32'(wr_ready), 32'(lvl < DEPTH));
      chk("empty", 32'(empty), 32'(lvl == 0));
      // uart_tx sees send on the edge after the pulse and raises busy for a frame.
      if (send_prev) busy_cnt = $urandom_range(frame_hi, frame_lo);
      tx_busy = force_busy || (busy_cnt != 0);
      if (busy_cnt != 0) busy_cnt--;
      send_prev = tx_send;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((model_q.size() != 0 || busy_cnt != 0 || send_prev || tx_busy) && n < 3000) begin
         step(1'b0, 8'h00);
         n++;
      end
      chk("drain_in_budget", 32'(n < 3000), 32'd1);
      repeat (3) step(1'b0, 8'h00);
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      wr_valid = 1'b0;
      #1;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_tx_send", 32'(tx_send), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
`ifdef UART_TX_FIFO_STATS_EN
      chk("rst_sent_count", 32'(sent_count), 32'd0);
      chk("rst_hi_water", 32'(hi_water), 32'd0);
`endif
      model_q.delete();
      pushes     = 0;
      sends      = 0;
      hi_model   = 0;
      last_sent  = 8'h00;
      busy_cnt   = 0;
      send_prev  = 1'b0;
      force_busy = 1'b0;
      tx_busy    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int p0;
      bit first_seen;
      passes = 0; fails = 0; total = 0; edges = 0;
      wr_valid = 1'b0; wr_data = 8'h00; tx_busy = 1'b0; reset_n = 1'b1;
      frame_lo = 10; frame_hi = 10;
      @(negedge clk);
      do_reset();

      // Single byte with a 10-cycle frame: written on edge E, tx_send visible
      // right after edge E+1 (cycle N+2 relative to write cycle N).
      step(1'b1, 8'h41);
      p0 = edges;
      send_edge = -1;
      for (int i = 0; i < 20 && send_edge < 0; i++) step(1'b0, 8'h00);
      chk("single_sent", 32'(send_edge >= 0), 32'd1);
      chk("single_latency", 32'(send_edge - p0), 32'd1);
      drain();
      chk("single_data_after", 32'(tx_data), 32'h41);
      chk("single_send_count", 32'(sends), 32'd1);

      // Fill with busy held high; the 17th write must be refused.
      frame_lo = 2; frame_hi = 12;
      force_busy = 1'b1; tx_busy = 1'b1;
      p0 = pushes;
      for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i));
      chk("fill_level", 32'(level), 32'd16);
      chk("fill_wr_ready", 32'(wr_ready), 32'd0);
      step(1'b1, 8'hEE);
      chk("fill_reject", 32'(pushes - p0), 32'd16);
      force_busy = 1'b0;
      drain();

      // Ordered burst 00..0F against the busy model.
      p0 = sends;
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
      drain();
      chk("burst_send_count", 32'(sends - p0), 32'd16);

      // Concurrent push/pop at level 5.
      force_busy = 1'b1; tx_busy = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
      force_busy = 1'b0;
      step(1'b0, 8'h00);
      first_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 8'($urandom));
         if (tx_send && !first_seen) begin
            first_seen = 1'b1;
            chk("concurrent_level", 32'(level), 32'd5);
         end
      end
      chk("concurrent_popped", 32'(first_seen), 32'd1);
      drain();

      // Random traffic, including full-FIFO backpressure.
      for (int i = 0; i < 400; i++) step(($urandom_range(2, 0) == 0), 8'($urandom));
      drain();

      // Reset in the middle of traffic discards everything.
      for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom));
      do_reset();

      // 20 bytes with a 12-byte peak.
      force_busy = 1'b1; tx_busy = 1'b1;
      for (int i = 0; i < 12; i++) step(1'b1, 8'(8'hA0 + i));
      force_busy = 1'b0;
      drain();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'(8'hC0 + i));
         drain();
      end
      chk("stats_model_sends", 32'(sends), 32'd20);
      chk("stats_model_peak", 32'(hi_model), 32'd12);
`ifdef UART_TX_FIFO_STATS_EN
      chk("stats_sent_count", 32'(sent_count), 32'd20);
      chk("stats_hi_water", 32'(hi_water), 32'd12);
`endif

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
